// File: rtl/lab_seq_ctrl.sv
// Stimulus sequencer / result collector for the a/b lab datapath.
// Walks STEPS vectors, holds each HOLD+2 cycles, captures {a,b,y,z,r,s} at the end of each.
`timescale 1ns/1ps
module lab_seq_ctrl #(
  parameter int STEPS = 16,
  parameter int IDX_W = 4,
  parameter int HOLD  = 1
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_y,
  input  logic             dut_z,
  input  logic             dut_r,
  input  logic             dut_s,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] vec_idx,
  output logic             cap_valid,
  output logic [5:0]       cap_data,
  output logic [7:0]       z_count
);
  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_HOLD, S_CAPT} state_t;

  state_t           state, state_nx;
  logic [3:0]       hcnt, hcnt_d;
  logic             a_d, b_d, busy_d, done_d, cv_d;
  logic [5:0]       cd_d;
  logic [IDX_W-1:0] vi_d;
  logic [7:0]       zc_d;
  logic             last;
  logic [1:0]       enc_nx;

  // a/b are the two low index bits; zero-extend so IDX_W=1 yields a=0
  function automatic logic [1:0] enc(input logic [IDX_W-1:0] i);
    logic [8:0] x;
    x = 9'(i);
    return x[1:0];
  endfunction

  assign last   = (int'(vec_idx) == STEPS - 1);
  assign enc_nx = enc(vec_idx + 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      hcnt      <= '0;
      dut_a     <= 1'b0;
      dut_b     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      vec_idx   <= '0;
      cap_valid <= 1'b0;
      cap_data  <= '0;
      z_count   <= '0;
    end else begin
      state     <= state_nx;
      hcnt      <= hcnt_d;
      dut_a     <= a_d;
      dut_b     <= b_d;
      busy      <= busy_d;
      done      <= done_d;
      vec_idx   <= vi_d;
      cap_valid <= cv_d;
      cap_data  <= cd_d;
      z_count   <= zc_d;
    end
  end

  always_comb begin
    state_nx = state;
    if (state != S_IDLE && abort) state_nx = S_IDLE;
    else begin
      case (state)
        S_IDLE:  if (start && !abort) state_nx = S_DRIVE;
        S_DRIVE: state_nx = (HOLD == 0) ? S_CAPT : S_HOLD;
        S_HOLD:  if (hcnt == 4'd0) state_nx = S_CAPT;
        S_CAPT:  state_nx = last ? S_IDLE : S_DRIVE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    hcnt_d = hcnt;
    a_d    = dut_a;
    b_d    = dut_b;
    busy_d = busy;
    done_d = 1'b0;
    cv_d   = 1'b0;
    cd_d   = cap_data;
    vi_d   = vec_idx;
    zc_d   = z_count;
    if (state != S_IDLE && abort) begin
      // capture in flight is dropped; index and z_count are left as they were
      busy_d = 1'b0;
      a_d    = 1'b0;
      b_d    = 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start && !abort) begin
          vi_d   = '0;
          zc_d   = '0;
          busy_d = 1'b1;
          a_d    = 1'b0;
          b_d    = 1'b0;
        end
        S_DRIVE: hcnt_d = 4'(HOLD - 1);
        S_HOLD:  if (hcnt != 4'd0) hcnt_d = hcnt - 4'd1;
        S_CAPT: begin
          cv_d = 1'b1;
          cd_d = {dut_a, dut_b, dut_y, dut_z, dut_r, dut_s};
          if (dut_z && z_count != 8'hff) zc_d = z_count + 8'd1;
          if (last) begin
            done_d = 1'b1;
            busy_d = 1'b0;
            a_d    = 1'b0;
            b_d    = 1'b0;
          end else begin
            vi_d = vec_idx + 1'b1;
            a_d  = enc_nx[1];
            b_d  = enc_nx[0];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lab_seq_ctrl.sv
// Bench for lab_seq_ctrl: four instances with different STEPS/HOLD/IDX_W, random y/z/r/s,
// compared cycle by cycle against a timing-based model of the run.
`timescale 1ns/1ps
module tb_lab_seq_ctrl;
  localparam int NU = 4;
  localparam int ST [NU] = '{4, 1, 16, 256};
  localparam int HL [NU] = '{1, 0, 2, 0};
  localparam int IW [NU] = '{4, 1, 4, 8};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NU-1:0] st_v = '0, ab_v = '0, y_v = '0, z_v = '0, r_v = '0, s_v = '0;
  logic [NU-1:0] a_v, b_v, busy_v, done_v, cv_v;
  logic [5:0] cd_v [NU];
  logic [7:0] vi_v [NU];
  logic [7:0] zc_v [NU];

  int total = 0;
  int bad = 0;

  for (genvar g = 0; g < NU; g++) begin : g_u
    logic [IW[g]-1:0] vi;
    lab_seq_ctrl #(.STEPS(ST[g]), .IDX_W(IW[g]), .HOLD(HL[g])) u_dut (
      .clk(clk), .rst_n(rst_n), .start(st_v[g]), .abort(ab_v[g]),
      .dut_a(a_v[g]), .dut_b(b_v[g]), .dut_y(y_v[g]), .dut_z(z_v[g]),
      .dut_r(r_v[g]), .dut_s(s_v[g]), .busy(busy_v[g]), .done(done_v[g]),
      .vec_idx(vi), .cap_valid(cv_v[g]), .cap_data(cd_v[g]), .z_count(zc_v[g]));
    assign vi_v[g] = 8'(vi);
  end

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish got=timeout exp=finish");
    $fatal(1);
  end

  // model: a run is just a cycle count since the start edge; capture k lands on edge (k+1)*(HOLD+2)
  bit         m_act [NU];
  int         m_t   [NU];
  logic       e_busy[NU], e_done[NU], e_cv[NU];
  logic [1:0] e_ab  [NU];
  logic [5:0] e_cd  [NU];
  logic [7:0] e_vi  [NU], e_zc[NU];

  task automatic model_reset();
    for (int u = 0; u < NU; u++) begin
      m_act[u] = 0; m_t[u] = 0; e_busy[u] = 0; e_done[u] = 0; e_cv[u] = 0;
      e_ab[u] = 0; e_cd[u] = 0; e_vi[u] = 0; e_zc[u] = 0;
    end
  endtask

  task automatic model_edge(input int u, input bit st, input bit ab, input logic [3:0] q);
    int p, k;
    p = HL[u] + 2;
    e_done[u] = 0;
    e_cv[u] = 0;
    if (!m_act[u]) begin
      if (st && !ab) begin
        m_act[u] = 1; m_t[u] = 0; e_busy[u] = 1; e_vi[u] = 0; e_zc[u] = 0; e_ab[u] = 0;
      end
    end else if (ab) begin
      m_act[u] = 0; e_busy[u] = 0; e_ab[u] = 0;
    end else begin
      m_t[u] = m_t[u] + 1;
      if (m_t[u] % p == 0) begin
        k = m_t[u] / p - 1;
        e_cv[u] = 1;
        e_cd[u] = {2'(k), q};
        if (q[2] && e_zc[u] < 8'd255) e_zc[u] = e_zc[u] + 8'd1;
        if (k == ST[u] - 1) begin
          m_act[u] = 0; e_busy[u] = 0; e_done[u] = 1; e_ab[u] = 0;
        end else begin
          e_vi[u] = 8'(k + 1);
          e_ab[u] = 2'(k + 1);
        end
      end
    end
  endtask

  function automatic logic [26:0] obs(input int u);
    return {a_v[u], b_v[u], busy_v[u], done_v[u], cv_v[u], cd_v[u], vi_v[u], zc_v[u]};
  endfunction

  function automatic logic [26:0] expv(input int u);
    return {e_ab[u], e_busy[u], e_done[u], e_cv[u], e_cd[u], e_vi[u], e_zc[u]};
  endfunction

  // drive one cycle on unit u: inputs change on negedge, outputs looked at 1ns after posedge
  task automatic tick(input int u, input bit st, input bit ab, input bit fz);
    logic [3:0] q;
    @(negedge clk);
    q = 4'($urandom);
    if (fz) q[2] = 1'b1;
    st_v = '0; ab_v = '0;
    st_v[u] = st; ab_v[u] = ab;
    {y_v[u], z_v[u], r_v[u], s_v[u]} = q;
    @(posedge clk);
    model_edge(u, st, ab, q);
    #1;
  endtask

  task automatic test_reset();
    for (int u = 0; u < NU; u++) begin
      total++;
      if (obs(u) !== 27'd0) begin
        bad++; $display("FAIL reset_init u=%0d got=%h exp=0", u, obs(u));
      end
    end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    tick(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0);
    total++;
    if (busy_v[0] !== 1'b1) begin
      bad++; $display("FAIL reset_prerun got=%b exp=1", busy_v[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int u = 0; u < NU; u++) begin
      total++;
      if (obs(u) !== 27'd0) begin
        bad++; $display("FAIL reset_async u=%0d got=%h exp=0", u, obs(u));
      end
    end
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 0);
      total++;
      if (obs(0) !== expv(0)) begin
        bad++; $display("FAIL reset_idle got=%h exp=%h", obs(0), expv(0));
      end
    end
  endtask

  task automatic test_basic();
    int nbusy, ncap, nz;
    nbusy = 0; ncap = 0; nz = 0;
    tick(0, 1, 0, 0);
    if (busy_v[0] === 1'b1) nbusy++;
    for (int i = 1; i <= 14; i++) begin
      tick(0, 0, 0, 0);
      if (busy_v[0] === 1'b1) nbusy++;
      total++;
      if (obs(0) !== expv(0)) begin
        bad++; $display("FAIL basic t=%0d got=%h exp=%h", i, obs(0), expv(0));
      end
      if (cv_v[0] === 1'b1) begin
        total++;
        if (cd_v[0][5:4] !== 2'(ncap) || (i % 3) != 0) begin
          bad++; $display("FAIL basic_capidx t=%0d got=%0d exp=%0d", i, cd_v[0][5:4], ncap);
        end
        ncap++;
        if (cd_v[0][2] === 1'b1) nz++;
      end
      if (i == 12) begin
        total++;
        if (done_v[0] !== 1'b1) begin
          bad++; $display("FAIL basic_done got=%b exp=1", done_v[0]);
        end
      end
    end
    total++;
    if (nbusy != 12 || ncap != 4) begin
      bad++; $display("FAIL basic_len got=%0d/%0d exp=12/4", nbusy, ncap);
    end
    total++;
    if (zc_v[0] !== 8'(nz)) begin
      bad++; $display("FAIL basic_zcount got=%0d exp=%0d", zc_v[0], nz);
    end
  endtask

  task automatic test_min();
    tick(1, 1, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      tick(1, 0, 0, 0);
      total++;
      if (obs(1) !== expv(1)) begin
        bad++; $display("FAIL min t=%0d got=%h exp=%h", i, obs(1), expv(1));
      end
      if (i == 2) begin
        total++;
        if ({cv_v[1], done_v[1], busy_v[1], a_v[1], b_v[1]} !== 5'b11000) begin
          bad++; $display("FAIL min_end got=%b exp=11000",
                          {cv_v[1], done_v[1], busy_v[1], a_v[1], b_v[1]});
        end
      end
    end
  endtask

  task automatic test_abort();
    int ncap, guard;
    ncap = 0; guard = 0;
    tick(2, 1, 0, 0);
    while (ncap < 2 && guard < 40) begin
      tick(2, 0, 0, 0);
      guard++;
      if (cv_v[2] === 1'b1) ncap++;
      total++;
      if (obs(2) !== expv(2)) begin
        bad++; $display("FAIL abort_pre t=%0d got=%h exp=%h", guard, obs(2), expv(2));
      end
    end
    total++;
    if (ncap != 2) begin
      bad++; $display("FAIL abort_caps got=%0d exp=2", ncap);
    end
    tick(2, 0, 1, 0);
    total++;
    if ({busy_v[2], cv_v[2], done_v[2], a_v[2], b_v[2], vi_v[2]} !== {5'b00000, 8'd2}) begin
      bad++; $display("FAIL abort_stop got=%b vi=%0d exp=00000 vi=2",
                      {busy_v[2], cv_v[2], done_v[2], a_v[2], b_v[2]}, vi_v[2]);
    end
    for (int i = 0; i < 12; i++) begin
      tick(2, 0, 0, 0);
      total++;
      if (obs(2) !== expv(2) || cv_v[2] !== 1'b0 || done_v[2] !== 1'b0) begin
        bad++; $display("FAIL abort_post i=%0d got=%h exp=%h", i, obs(2), expv(2));
      end
    end
  endtask

  task automatic test_start_ignored();
    int seen;
    bit st;
    seen = 0;
    tick(2, 1, 0, 0);
    for (int i = 1; i <= 64; i++) begin
      st = ($urandom_range(0, 3) == 0) || (i == 64);
      tick(2, st, 0, 0);
      total++;
      if (obs(2) !== expv(2)) begin
        bad++; $display("FAIL start_busy t=%0d got=%h exp=%h", i, obs(2), expv(2));
      end
      if (cv_v[2] === 1'b1) begin
        total++;
        if (cd_v[2][5:4] !== 2'(seen)) begin
          bad++; $display("FAIL start_seq t=%0d got=%0d exp=%0d", i, cd_v[2][5:4], 2'(seen));
        end
        seen++;
      end
    end
    total++;
    if (done_v[2] !== 1'b1 || vi_v[2] !== 8'd15 || seen != 16) begin
      bad++; $display("FAIL start_done got=%b/%0d/%0d exp=1/15/16", done_v[2], vi_v[2], seen);
    end
    tick(2, 1, 1, 0);
    total++;
    if (busy_v[2] !== 1'b0 || obs(2) !== expv(2)) begin
      bad++; $display("FAIL start_abort_idle got=%h exp=%h", obs(2), expv(2));
    end
    tick(2, 0, 0, 0);
    total++;
    if (busy_v[2] !== 1'b0) begin
      bad++; $display("FAIL start_abort_idle2 got=%b exp=0", busy_v[2]);
    end
  endtask

  task automatic test_saturation();
    tick(3, 1, 0, 1);
    for (int i = 1; i <= 513; i++) begin
      tick(3, 0, 0, 1);
      total++;
      if (obs(3) !== expv(3)) begin
        bad++; $display("FAIL sat t=%0d got=%h exp=%h", i, obs(3), expv(3));
      end
      if (i == 512) begin
        total++;
        if (done_v[3] !== 1'b1 || zc_v[3] !== 8'd255) begin
          bad++; $display("FAIL sat_end got=%b/%0d exp=1/255", done_v[3], zc_v[3]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    #12;
    test_reset();
    test_basic();
    test_min();
    test_abort();
    test_start_ignored();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
